// File: rtl/board_debug_monitor.sv
// On-board debug monitor: slow bus clock generator (run/halt/single-step),
// debounced push-buttons, and a paged, freezable seven-segment probe display.
module board_debug_monitor #(
    parameter int NUM_CH   = 8,
    parameter int DIV_HALF = 25000000,
    parameter int DB_CYC   = 500000,
    parameter int PAGE_W   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  step_key_n,
    input  logic                  page_key_n,
    input  logic                  freeze_key_n,
    input  logic [NUM_CH*8-1:0]   probe_bus,
    output logic                  slow_clk,
    output logic                  slow_tick,
    output logic [PAGE_W-1:0]     page,
    output logic                  frozen,
    output logic [6:0]            hex0,
    output logic [6:0]            hex1,
    output logic [6:0]            hex2,
    output logic [6:0]            hex3,
    output logic [6:0]            hex4,
    output logic [6:0]            hex5,
    output logic [6:0]            hex6,
    output logic [6:0]            hex7
);

    localparam int NUM_PAGES = NUM_CH / 4;
    localparam int CNT_W     = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam int DB_W      = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam int PAD_CH    = 4 * (2 ** PAGE_W);

    // Key index: 0 = step, 1 = page, 2 = freeze.
    logic [2:0]      key_raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      level;
    logic [2:0]      press;
    logic [DB_W-1:0] db_cnt [3];

    assign key_raw = {freeze_key_n, page_key_n, step_key_n};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '1;
            sync2 <= '1;
            level <= '1;
            press <= '0;
            for (int k = 0; k < 3; k++) db_cnt[k] <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            press <= '0;
            for (int k = 0; k < 3; k++) begin
                if (sync2[k] == level[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_W'(DB_CYC - 1)) begin
                    level[k]  <= sync2[k];
                    db_cnt[k] <= '0;
                    press[k]  <= ~sync2[k];
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

    // A period in progress (high half, or count away from zero) always runs
    // to completion, which covers both single steps and run dropping mid-period.
    logic [CNT_W-1:0] div_cnt;
    logic             div_active;
    logic             div_wrap;

    always_comb begin
        div_active = run || slow_clk || (div_cnt != '0) || press[0];
        div_wrap   = (div_cnt == CNT_W'(DIV_HALF - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt   <= '0;
            slow_clk  <= 1'b0;
            slow_tick <= 1'b0;
        end else begin
            slow_tick <= div_active && div_wrap && !slow_clk;
            if (div_active) begin
                if (div_wrap) begin
                    div_cnt  <= '0;
                    slow_clk <= ~slow_clk;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

    logic [PAGE_W-1:0]   next_page;
    logic [NUM_CH*8-1:0] snapshot;

    always_comb begin
        if (NUM_PAGES <= 1 || int'(page) == NUM_PAGES - 1) next_page = '0;
        else                                               next_page = page + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            page     <= '0;
            frozen   <= 1'b0;
            snapshot <= '0;
        end else begin
            if (press[1]) page   <= next_page;
            if (press[2]) frozen <= ~frozen;
            if (!frozen)  snapshot <= probe_bus;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Snapshot is zero-padded to every page code so page selection never indexes out of range.
    logic [PAD_CH*8-1:0] snap_pad;
    logic [7:0]          chan [PAD_CH];
    logic [7:0]          chan_sel [4];
    logic [PAGE_W+1:0]   sel_idx [4];
    logic [6:0]          hex_q [8];

    always_comb begin
        snap_pad = (PAD_CH*8)'(snapshot);
        for (int c = 0; c < PAD_CH; c++) chan[c] = snap_pad[c*8 +: 8];
        for (int j = 0; j < 4; j++) begin
            sel_idx[j]  = {page, 2'(j)};
            chan_sel[j] = chan[sel_idx[j]];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int h = 0; h < 8; h++) hex_q[h] <= 7'b1000000;
        end else begin
            for (int j = 0; j < 4; j++) begin
                hex_q[2*j]   <= seg7(chan_sel[j][3:0]);
                hex_q[2*j+1] <= seg7(chan_sel[j][7:4]);
            end
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];
    assign hex6 = hex_q[6];
    assign hex7 = hex_q[7];

endmodule
